layer_out_packer: RTL and testbench
===================================

Name: layer_out_packer

Overview:
- Writer-side counterpart of the layer00 input buffer port.
- Consumes the per-pixel 4-channel 8-bit stream produced by a conv layer (one pixel of ch0..ch3 per valid cycle).
- Packs 4 consecutive pixels into one 128-bit word and drives the banked buffer write interface (ena/addra/wea/dia) of the next layer's parsing buffer.
- Tracks the frame raster and signals frame completion.

Parameters:
- IMG_W, 128, output feature-map width in pixels; multiple of 4.
- IMG_H, 128, output feature-map height in rows; multiple of BANKS.
- BANKS, 16, number of buffer banks; row r goes to bank r mod BANKS.
- ADDR_W, 9, buffer address width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- iStart  in  1  one-cycle pulse, arms capture of a new frame
- i_vld  in  1  pixel valid
- i_ch0  in  8  channel 0 pixel value
- i_ch1  in  8  channel 1 pixel value
- i_ch2  in  8  channel 2 pixel value
- i_ch3  in  8  channel 3 pixel value
- o_ena  out  16  one-hot bank enable
- o_addra  out  9  write address within bank
- o_wea  out  16  one-hot bank write enable, equal to o_ena
- o_dia  out  128  packed write data
- o_busy  out  1  high in PACK
- o_done  out  1  one-cycle pulse after the last word of the frame is written

Behaviour:
- Reset: synchronous on rising clk with rstn=0.
  - All outputs are 0; FSM goes to IDLE; counters and pack register are cleared.
  - A reset mid-frame abandons the frame; no further writes are issued.
- FSM states: IDLE, PACK, DONE.
  - IDLE -> PACK on iStart.
  - PACK -> DONE on the cycle the last word of the frame is issued.
  - DONE -> IDLE unconditionally after one cycle; o_done=1 only in DONE.
- i_vld outside PACK is ignored. iStart outside IDLE is ignored.
- Counters:
  - px (0..3): pixel-in-word index.
  - wcol (0..IMG_W/4-1): word column.
  - row (0..IMG_H-1).
- Packing: on each i_vld in PACK, the pixel's 32 bits {i_ch3,i_ch2,i_ch1,i_ch0} go to dia lane [32*px+31 : 32*px]. Pixel 0 occupies the LSBs.
- Word issue, on the i_vld with px=3:
  - The next cycle drives o_dia = full packed word, o_ena = o_wea = 1<<(row mod BANKS), o_addra = (row/BANKS)*(IMG_W/4) + wcol.
  - Enables are high for exactly one cycle; otherwise o_ena and o_wea are 0.
  - o_dia and o_addra hold their last value when not writing.
- Latency: 1 cycle from the 4th pixel to the write strobe.
- Back-to-back: i_vld every cycle is supported. Filling the next word proceeds in parallel with issuing the current one.
- Counter wrap:
  - px wraps 3->0.
  - wcol wraps at IMG_W/4-1 and increments row.
  - row at IMG_H-1 with the final wcol ends the frame.
- Defaults: 256 words per bank, max address 255, which fits in ADDR_W=9.
- Arithmetic: addresses are unsigned and computed from counters. No data modification.

Optional Feature:
- Macro: LAYER_OUT_PACKER_ERR_EN.
- Defined:
  - Adds output o_err (1 bit), sticky.
  - o_err is set when i_vld=1 in IDLE or DONE, or when iStart=1 in PACK.
  - o_err is cleared only by reset or by an accepted iStart in IDLE.
- Not defined: no o_err port; such events are silently ignored.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/PACK/DONE;
  - BANKS and the data width constant 128;
  - a function computing words-per-row (IMG_W/4).
- One natural sub-module: layer_out_addr_gen. It holds the px/wcol/row counters and produces the bank one-hot, the address and the last-word flag. The top level holds the FSM and the pack register.

Test Plan:
- Reset mid-frame: iStart, 6 valid pixels, rstn=0 for 1 cycle, then 8 more i_vld -> no o_ena activity after reset; o_busy=0.
- Single word: iStart, then pixels 0..3 with ch0..3 = {0x10+p, 0x20+p, 0x30+p, 0x40+p} -> one cycle with o_ena=0x0001, o_addra=0, o_dia=0x43332313_42322212_41312111_40302010.
- Bank/address mapping: full-rate frame -> row 17 wcol 5 writes o_ena=0x0002, o_addra=37; row 127 wcol 31 writes o_ena=0x8000, o_addra=255.
- Frame end: 16384 valid pixels at full rate -> exactly 4096 write strobes; o_done pulses 1 cycle after the last strobe; FSM returns to IDLE; the next i_vld is ignored.
- Gapped input: i_vld with random gaps (50% duty) -> write sequence identical to the full-rate run; each strobe exactly 1 cycle after its 4th pixel.
- With LAYER_OUT_PACKER_ERR_EN: i_vld in IDLE sets o_err=1 and it stays set; the next iStart clears it and capture proceeds normally.

Source files
------------

// File: rtl/layer_out_packer_pkg.sv
// Shared definitions for the conv-layer output packer.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package layer_out_packer_pkg;

    // Packer FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_BANKS = 16;   // banks in the next layer's parsing buffer
    localparam int DATA_W    = 128;  // one buffer word = 4 pixels x 4 channels x 8 bits
    localparam int PIX_W     = 32;   // one pixel = 4 channels x 8 bits

    // Four pixels share one buffer word, so a row of IMG_W pixels spans IMG_W/4 words.
    function automatic int wordsPerRow(input int imgW);
        return imgW / 4;
    endfunction

endpackage

// File: rtl/layer_out_addr_gen.sv
// Raster tracker for the packer: pixel-in-word, word column and row counters.
// Latency: combinational outputs from the current counter state; counters step on adv.
// Backpressure: none; advances only on accepted pixels, restarts on clr.
//
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   clr           restart the raster at pixel 0 / word 0 / row 0
//   adv           one pixel accepted this cycle
//   px            pixel index within the word being filled (0..3)
//   wordEnd       adv on the 4th pixel of a word (word is complete)
//   lastWord      counters sit on the final word of the frame
//   bankOh        one-hot bank for the current row (row mod BANKS)
//   addr          write address of the current word within its bank
module layer_out_addr_gen
    import layer_out_packer_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int BANKS  = NUM_BANKS,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              adv,
    output logic [1:0]        px,
    output logic              wordEnd,
    output logic              lastWord,
    output logic [BANKS-1:0]  bankOh,
    output logic [ADDR_W-1:0] addr
);

    localparam int WPR    = wordsPerRow(IMG_W);
    localparam int WCOL_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [WCOL_W-1:0] WCOL_LAST = WCOL_W'(WPR - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);

    logic [WCOL_W-1:0] wcol;
    logic [ROW_W-1:0]  row;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            px   <= 2'd0;
            wcol <= '0;
            row  <= '0;
        end else if (adv) begin
            px <= px + 2'd1;
            if (px == 2'd3) begin
                if (wcol == WCOL_LAST) begin
                    wcol <= '0;
                    row  <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    wcol <= wcol + WCOL_W'(1);
                end
            end
        end
    end

    assign wordEnd  = adv && (px == 2'd3);
    assign lastWord = (wcol == WCOL_LAST) && (row == ROW_LAST);

    // Rows interleave across banks; each bank holds IMG_H/BANKS rows of WPR words.
    assign bankOh = BANKS'(1) << (32'(row) % BANKS);
    assign addr   = ADDR_W'((32'(row) / BANKS) * WPR + 32'(wcol));

endmodule

// File: rtl/layer_out_packer.sv
// Packs the conv layer's per-pixel 4x8-bit stream into 128-bit words and writes them to the banked buffer.
// Latency: 1 cycle from the 4th pixel of a word to its write strobe.
// Backpressure: none; accepts i_vld every cycle while in PACK, drops pixels elsewhere.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   iStart                     one-cycle pulse arming capture of a frame (honoured in IDLE only)
//   i_vld, i_ch0..i_ch3        pixel valid and its four 8-bit channels
//   o_ena, o_wea               one-hot bank enable / write enable, high one cycle per word
//   o_addra, o_dia             word address within the bank and packed data (held between writes)
//   o_busy                     high while capturing a frame
//   o_done                     one-cycle pulse after the frame's last word is written
//   o_err                      sticky protocol error, only with LAYER_OUT_PACKER_ERR_EN defined
//
// Optional feature macro: LAYER_OUT_PACKER_ERR_EN
module layer_out_packer
    import layer_out_packer_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int BANKS  = NUM_BANKS,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iStart,
    input  logic              i_vld,
    input  logic [7:0]        i_ch0,
    input  logic [7:0]        i_ch1,
    input  logic [7:0]        i_ch2,
    input  logic [7:0]        i_ch3,
    output logic [BANKS-1:0]  o_ena,
    output logic [ADDR_W-1:0] o_addra,
    output logic [BANKS-1:0]  o_wea,
    output logic [DATA_W-1:0] o_dia,
    output logic              o_busy,
`ifdef LAYER_OUT_PACKER_ERR_EN
    output logic              o_done,
    output logic              o_err
`else
    output logic              o_done
`endif
);

    state_t              state;
    // Only lanes 0..2 are stored; the 4th pixel goes straight into o_dia.
    logic [3*PIX_W-1:0]  packReg;
    // Final word has been issued; wait for its strobe cycle, then finish.
    logic                lastPending;

    logic [PIX_W-1:0]    pixIn;
    logic                startAcc;
    logic                accept;

    logic [1:0]          px;
    logic                wordEnd;
    logic                lastWord;
    logic [BANKS-1:0]    bankOh;
    logic [ADDR_W-1:0]   addr;

    assign pixIn    = {i_ch3, i_ch2, i_ch1, i_ch0};
    assign startAcc = (state == IDLE) && iStart;
    // Pixels arriving after the frame's last word are not part of this frame.
    assign accept   = (state == PACK) && i_vld && !lastPending;

    layer_out_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .BANKS  (BANKS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (startAcc),
        .adv      (accept),
        .px       (px),
        .wordEnd  (wordEnd),
        .lastWord (lastWord),
        .bankOh   (bankOh),
        .addr     (addr)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            packReg     <= '0;
            lastPending <= 1'b0;
            o_ena       <= '0;
            o_wea       <= '0;
            o_addra     <= '0;
            o_dia       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
`ifdef LAYER_OUT_PACKER_ERR_EN
            o_err       <= 1'b0;
`endif
        end else begin
            o_ena  <= '0;
            o_wea  <= '0;
            o_done <= 1'b0;

            if (accept) begin
                case (px)
                    2'd0:    packReg[31:0]  <= pixIn;
                    2'd1:    packReg[63:32] <= pixIn;
                    2'd2:    packReg[95:64] <= pixIn;
                    default: ;
                endcase
            end

            // Filling of the next word continues while this one is on the bus.
            if (wordEnd) begin
                o_dia   <= {pixIn, packReg};
                o_addra <= addr;
                o_ena   <= bankOh;
                o_wea   <= bankOh;
                if (lastWord) begin
                    lastPending <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (iStart) begin
                        state       <= PACK;
                        o_busy      <= 1'b1;
                        lastPending <= 1'b0;
                    end
                end
                PACK: begin
                    // Leave on the cycle the final strobe is on the bus, so o_done trails it by one.
                    if (lastPending) begin
                        state       <= DONE;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        lastPending <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

`ifdef LAYER_OUT_PACKER_ERR_EN
            if (startAcc) begin
                o_err <= 1'b0;
            end else if ((i_vld && (state != PACK)) || (iStart && (state == PACK))) begin
                o_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_layer_out_packer.sv
// Randomized self-checking bench for layer_out_packer against a raster-arithmetic reference.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_layer_out_packer;

    localparam int NPIX  = 16384;
    localparam int NWORD = NPIX / 4;

    logic         clk;
    logic         rstn;
    logic         iStart;
    logic         i_vld;
    logic [7:0]   i_ch0, i_ch1, i_ch2, i_ch3;
    logic [15:0]  o_ena;
    logic [8:0]   o_addra;
    logic [15:0]  o_wea;
    logic [127:0] o_dia;
    logic         o_busy;
    logic         o_done;
`ifdef LAYER_OUT_PACKER_ERR_EN
    logic         o_err;
`endif

    layer_out_packer dut (
        .clk     (clk),
        .rstn    (rstn),
        .iStart  (iStart),
        .i_vld   (i_vld),
        .i_ch0   (i_ch0),
        .i_ch1   (i_ch1),
        .i_ch2   (i_ch2),
        .i_ch3   (i_ch3),
        .o_ena   (o_ena),
        .o_addra (o_addra),
        .o_wea   (o_wea),
        .o_dia   (o_dia),
        .o_busy  (o_busy),
`ifdef LAYER_OUT_PACKER_ERR_EN
        .o_done  (o_done),
        .o_err   (o_err)
`else
        .o_done  (o_done)
`endif
    );

    typedef struct {
        int unsigned  cyc;
        logic [15:0]  ena;
        logic [15:0]  wea;
        logic [8:0]   addr;
        logic [127:0] dia;
    } wr_t;

    wr_t          wrQ[$];
    wr_t          refQ[$];
    int unsigned  doneQ[$];
    logic [31:0]  pix [NPIX];
    int unsigned  pixCyc [NPIX];
    int unsigned  cyc = 0;
    int           vecs = 0;
    int           errs = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe and done pulse is logged mid-cycle for later comparison.
    always @(negedge clk) begin
        if (o_ena != 16'h0 || o_wea != 16'h0)
            wrQ.push_back('{cyc, o_ena, o_wea, o_addra, o_dia});
        if (o_done)
            doneQ.push_back(cyc);
    end

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic startFrame();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic drivePix(input logic [31:0] p, output int unsigned c);
        i_vld = 1'b1;
        {i_ch3, i_ch2, i_ch1, i_ch0} = p;
        c = cyc;
        tick();
        i_vld = 1'b0;
    endtask

    // Reference placement: word k holds pixels 4k..4k+3 of a raster with 32 words per row,
    // rows interleaved over 16 banks, 32 words per row slot within a bank.
    task automatic expWord(input int k, output logic [15:0] ena, output logic [8:0] addr,
                           output logic [127:0] dia);
        int row, wcol;
        row  = k / 32;
        wcol = k % 32;
        ena  = 16'(1 << (row % 16));
        addr = 9'((row / 16) * 32 + wcol);
        dia  = {pix[4*k+3], pix[4*k+2], pix[4*k+1], pix[4*k]};
    endtask

    task automatic runFrame(input bit gapped);
        int unsigned c;
        startFrame();
        for (int n = 0; n < NPIX; n++) begin
            if (gapped) begin
                for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) tick();
            end
            drivePix(pix[n], c);
            pixCyc[n] = c;
            if (n == NPIX / 2) checkVal("busy_mid_frame", o_busy, 1);
        end
        repeat (4) tick();
    endtask

    task automatic checkFrame(input string nm);
        logic [15:0]  eEna;
        logic [8:0]   eAddr;
        logic [127:0] eDia;
        checkVal({nm, "_strobes"}, wrQ.size(), NWORD);
        for (int k = 0; k < NWORD && k < wrQ.size(); k++) begin
            expWord(k, eEna, eAddr, eDia);
            checkVal($sformatf("%s_ena[%0d]", nm, k), wrQ[k].ena, eEna);
            checkVal($sformatf("%s_wea[%0d]", nm, k), wrQ[k].wea, eEna);
            checkVal($sformatf("%s_addr[%0d]", nm, k), wrQ[k].addr, eAddr);
            checkVal($sformatf("%s_dia[%0d]", nm, k), wrQ[k].dia, eDia);
            checkVal($sformatf("%s_lat[%0d]", nm, k), wrQ[k].cyc, pixCyc[4*k+3] + 1);
        end
        checkVal({nm, "_done_count"}, doneQ.size(), 1);
        if (doneQ.size() > 0 && wrQ.size() > 0)
            checkVal({nm, "_done_cyc"}, doneQ[0], wrQ[wrQ.size()-1].cyc + 1);
        checkVal({nm, "_busy_after"}, o_busy, 0);
    endtask

    initial begin
        int unsigned c;
        rstn   = 1'b0;
        iStart = 1'b0;
        i_vld  = 1'b0;
        {i_ch3, i_ch2, i_ch1, i_ch0} = 32'h0;
        repeat (3) tick();

        // Reset state
        checkVal("rst_ena", o_ena, 0);
        checkVal("rst_wea", o_wea, 0);
        checkVal("rst_addra", o_addra, 0);
        checkVal("rst_dia", o_dia, 0);
        checkVal("rst_busy", o_busy, 0);
        checkVal("rst_done", o_done, 0);
`ifdef LAYER_OUT_PACKER_ERR_EN
        checkVal("rst_err", o_err, 0);
`endif
        rstn = 1'b1;
        tick();

        // Reset mid-frame abandons the frame
        startFrame();
        for (int p = 0; p < 6; p++) drivePix($urandom, c);
        doReset();
        wrQ.delete();
        for (int p = 0; p < 8; p++) drivePix($urandom, c);
        repeat (3) tick();
        checkVal("midrst_strobes", wrQ.size(), 0);
        checkVal("midrst_busy", o_busy, 0);
        doReset();
        wrQ.delete();
        doneQ.delete();

        // Single word with known data
        startFrame();
        for (int p = 0; p < 4; p++) begin
            drivePix(32'h40302010 + 32'(p) * 32'h01010101, c);
            pixCyc[p] = c;
        end
        repeat (3) tick();
        checkVal("single_strobes", wrQ.size(), 1);
        if (wrQ.size() > 0) begin
            checkVal("single_ena", wrQ[0].ena, 16'h0001);
            checkVal("single_wea", wrQ[0].wea, 16'h0001);
            checkVal("single_addr", wrQ[0].addr, 0);
            checkVal("single_dia", wrQ[0].dia, 128'h43332313_42322212_41312111_40302010);
            checkVal("single_lat", wrQ[0].cyc, pixCyc[3] + 1);
        end
        checkVal("single_hold_addr", o_addra, 0);
        checkVal("single_hold_dia", o_dia, 128'h43332313_42322212_41312111_40302010);
        checkVal("single_busy", o_busy, 1);
        doReset();
        wrQ.delete();
        doneQ.delete();

        // Full-rate frame
        for (int n = 0; n < NPIX; n++) pix[n] = $urandom;
        runFrame(1'b0);
        checkFrame("full");
        if (wrQ.size() > 549) begin
            checkVal("map_r17c5_ena", wrQ[549].ena, 16'h0002);
            checkVal("map_r17c5_addr", wrQ[549].addr, 37);
        end
        if (wrQ.size() > 4095) begin
            checkVal("map_last_ena", wrQ[4095].ena, 16'h8000);
            checkVal("map_last_addr", wrQ[4095].addr, 255);
        end
        refQ = wrQ;
        wrQ.delete();
        doneQ.delete();
        // Back in IDLE: pixels are dropped
        for (int p = 0; p < 4; p++) drivePix($urandom, c);
        repeat (3) tick();
        checkVal("idle_ignore_strobes", wrQ.size(), 0);
        checkVal("idle_ignore_busy", o_busy, 0);
        doReset();
        wrQ.delete();
        doneQ.delete();

        // Gapped frame with the same pixels
        runFrame(1'b1);
        checkFrame("gap");
        for (int k = 0; k < NWORD && k < wrQ.size() && k < refQ.size(); k++) begin
            checkVal($sformatf("gap_vs_full_dia[%0d]", k), wrQ[k].dia, refQ[k].dia);
            checkVal($sformatf("gap_vs_full_addr[%0d]", k), wrQ[k].addr, refQ[k].addr);
        end
        wrQ.delete();
        doneQ.delete();

`ifdef LAYER_OUT_PACKER_ERR_EN
        // Sticky error on a stray pixel in IDLE, cleared by the next start
        doReset();
        wrQ.delete();
        checkVal("err_clear", o_err, 0);
        drivePix($urandom, c);
        checkVal("err_set", o_err, 1);
        repeat (3) tick();
        checkVal("err_sticky", o_err, 1);
        startFrame();
        checkVal("err_cleared_by_start", o_err, 0);
        for (int p = 0; p < 4; p++) begin
            pix[p] = $urandom;
            drivePix(pix[p], c);
        end
        repeat (2) tick();
        checkVal("err_frame_strobes", wrQ.size(), 1);
        if (wrQ.size() > 0)
            checkVal("err_frame_dia", wrQ[0].dia, {pix[3], pix[2], pix[1], pix[0]});
        checkVal("err_stays_clear", o_err, 0);
        doReset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
